// File: rtl/ctrlport_arbiter_2to1_if.sv
// Control-port bundle: request pulses with address/data and the matching response.
// The master modport drives requests; the slave modport drives responses.
interface ctrlport_arbiter_2to1_if;
    logic        req_wr;
    logic        req_rd;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic        resp_ack;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;

    modport master (
        output req_wr, req_rd, req_addr, req_data,
        input  resp_ack, resp_status, resp_data
    );

    modport slave (
        input  req_wr, req_rd, req_addr, req_data,
        output resp_ack, resp_status, resp_data
    );
endinterface

// File: rtl/ctrlport_arbiter_2to1.sv
// Two-port round-robin arbiter sharing one control-port slave, one slot per port.
// Define CTRLPORT_ARBITER_TIMEOUT_EN to answer unacknowledged requests with CMDERR.
module ctrlport_arbiter_2to1 #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           ctrlport_clk,
    input  logic                           ctrlport_rst_n,
    ctrlport_arbiter_2to1_if.slave         s0_ctrlport,
    ctrlport_arbiter_2to1_if.slave         s1_ctrlport,
    ctrlport_arbiter_2to1_if.master        m_ctrlport,
    output logic [1:0]                     overflow
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e      r_state_q, r_state_d;

    logic [1:0]  w_req;
    logic [1:0]  w_req_wr;
    logic [19:0] w_req_addr [2];
    logic [31:0] w_req_data [2];

    logic [1:0]  r_slot_vld_q;
    logic [1:0]  r_slot_wr_q;
    logic [19:0] r_slot_addr_q [2];
    logic [31:0] r_slot_data_q [2];
    logic [1:0]  r_overflow_q;

    logic        r_grant_q;
    logic        r_m_wr_q;
    logic        r_m_rd_q;
    logic [19:0] r_m_addr_q;
    logic [31:0] r_m_data_q;
    logic        r_resp_ack_q;
    logic        r_resp_port_q;
    logic [1:0]  r_resp_status_q;
    logic [31:0] r_resp_data_q;

    logic        w_pick;
    logic        w_grant_en;
    logic        w_done;
    logic        w_timeout;
    logic [1:0]  w_clr;
    logic        w_s0_sel;
    logic        w_s1_sel;

    // Simultaneous wr and rd is treated as a write.
    assign w_req[0]      = s0_ctrlport.req_wr | s0_ctrlport.req_rd;
    assign w_req[1]      = s1_ctrlport.req_wr | s1_ctrlport.req_rd;
    assign w_req_wr[0]   = s0_ctrlport.req_wr;
    assign w_req_wr[1]   = s1_ctrlport.req_wr;
    assign w_req_addr[0] = s0_ctrlport.req_addr;
    assign w_req_addr[1] = s1_ctrlport.req_addr;
    assign w_req_data[0] = s0_ctrlport.req_data;
    assign w_req_data[1] = s1_ctrlport.req_data;

    // r_grant_q doubles as "last granted"; reset value 0 lets port 1 win first.
    assign w_pick = (&r_slot_vld_q) ? ~r_grant_q : r_slot_vld_q[1];
    assign w_clr  = w_done ? (r_grant_q ? 2'b10 : 2'b01) : 2'b00;

`ifdef CTRLPORT_ARBITER_TIMEOUT_EN
    logic [15:0] r_tmo_cnt_q;

    // Counts WAIT cycles; WAIT cycle k sees a count of k-1.
    always_ff @(posedge ctrlport_clk) begin
        if (!ctrlport_rst_n) begin
            r_tmo_cnt_q <= '0;
        end else if (r_state_q == StIssue) begin
            r_tmo_cnt_q <= '0;
        end else if (r_state_q == StWait) begin
            r_tmo_cnt_q <= r_tmo_cnt_q + 16'd1;
        end
    end

    assign w_timeout = (r_state_q == StWait) && (r_tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        r_state_d  = r_state_q;
        w_grant_en = 1'b0;
        w_done     = 1'b0;
        unique case (r_state_q)
            StIdle: begin
                if (|r_slot_vld_q) begin
                    w_grant_en = 1'b1;
                    r_state_d  = StIssue;
                end
            end
            StIssue: begin
                if (m_ctrlport.resp_ack) begin
                    w_done    = 1'b1;
                    r_state_d = StIdle;
                end else begin
                    r_state_d = StWait;
                end
            end
            StWait: begin
                if (m_ctrlport.resp_ack || w_timeout) begin
                    w_done    = 1'b1;
                    r_state_d = StIdle;
                end
            end
            default: r_state_d = StIdle;
        endcase
    end

    always_ff @(posedge ctrlport_clk) begin
        if (!ctrlport_rst_n) begin
            r_state_q <= StIdle;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    // A slot being cleared this cycle may reload from a request in the same cycle.
    always_ff @(posedge ctrlport_clk) begin
        if (!ctrlport_rst_n) begin
            r_slot_vld_q <= '0;
            r_slot_wr_q  <= '0;
            r_overflow_q <= '0;
            for (int i = 0; i < 2; i++) begin
                r_slot_addr_q[i] <= '0;
                r_slot_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_req[i] && (!r_slot_vld_q[i] || w_clr[i])) begin
                    r_slot_vld_q[i]  <= 1'b1;
                    r_slot_wr_q[i]   <= w_req_wr[i];
                    r_slot_addr_q[i] <= w_req_addr[i];
                    r_slot_data_q[i] <= w_req_data[i];
                end else begin
                    if (w_clr[i]) begin
                        r_slot_vld_q[i] <= 1'b0;
                    end
                    if (w_req[i]) begin
                        r_overflow_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge ctrlport_clk) begin
        if (!ctrlport_rst_n) begin
            r_grant_q       <= 1'b0;
            r_m_wr_q        <= 1'b0;
            r_m_rd_q        <= 1'b0;
            r_m_addr_q      <= '0;
            r_m_data_q      <= '0;
            r_resp_ack_q    <= 1'b0;
            r_resp_port_q   <= 1'b0;
            r_resp_status_q <= '0;
            r_resp_data_q   <= '0;
        end else begin
            r_m_wr_q <= w_grant_en & r_slot_wr_q[w_pick];
            r_m_rd_q <= w_grant_en & ~r_slot_wr_q[w_pick];
            if (w_grant_en) begin
                r_grant_q  <= w_pick;
                r_m_addr_q <= r_slot_addr_q[w_pick];
                r_m_data_q <= r_slot_data_q[w_pick];
            end
            r_resp_ack_q  <= w_done;
            r_resp_port_q <= r_grant_q;
            // A real ack on the timeout cycle takes precedence over CMDERR.
            if (w_done && m_ctrlport.resp_ack) begin
                r_resp_status_q <= m_ctrlport.resp_status;
                r_resp_data_q   <= m_ctrlport.resp_data;
            end else if (w_done) begin
                r_resp_status_q <= 2'b01;
                r_resp_data_q   <= '0;
            end else begin
                r_resp_status_q <= '0;
                r_resp_data_q   <= '0;
            end
        end
    end

    assign w_s0_sel = r_resp_ack_q & ~r_resp_port_q;
    assign w_s1_sel = r_resp_ack_q & r_resp_port_q;

    assign m_ctrlport.req_wr   = r_m_wr_q;
    assign m_ctrlport.req_rd   = r_m_rd_q;
    assign m_ctrlport.req_addr = r_m_addr_q;
    assign m_ctrlport.req_data = r_m_data_q;

    assign s0_ctrlport.resp_ack    = w_s0_sel;
    assign s0_ctrlport.resp_status = {2{w_s0_sel}} & r_resp_status_q;
    assign s0_ctrlport.resp_data   = {32{w_s0_sel}} & r_resp_data_q;
    assign s1_ctrlport.resp_ack    = w_s1_sel;
    assign s1_ctrlport.resp_status = {2{w_s1_sel}} & r_resp_status_q;
    assign s1_ctrlport.resp_data   = {32{w_s1_sel}} & r_resp_data_q;

    assign overflow = r_overflow_q;

endmodule

// File: tb/tb_ctrlport_arbiter_2to1.sv
// Directed bench for ctrlport_arbiter_2to1; timeout scenarios run when
// CTRLPORT_ARBITER_TIMEOUT_EN is defined.
module tb_ctrlport_arbiter_2to1;

    logic       clk;
    logic       rst_n;
    logic [1:0] overflow;
    int         n_checks;
    int         n_fail;

    ctrlport_arbiter_2to1_if s0_if ();
    ctrlport_arbiter_2to1_if s1_if ();
    ctrlport_arbiter_2to1_if m_if ();

    ctrlport_arbiter_2to1 #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ctrlport_clk   (clk),
        .ctrlport_rst_n (rst_n),
        .s0_ctrlport    (s0_if),
        .s1_ctrlport    (s1_if),
        .m_ctrlport     (m_if),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        s0_if.req_wr = 0; s0_if.req_rd = 0; s0_if.req_addr = '0; s0_if.req_data = '0;
        s1_if.req_wr = 0; s1_if.req_rd = 0; s1_if.req_addr = '0; s1_if.req_data = '0;
        m_if.resp_ack = 0; m_if.resp_status = '0; m_if.resp_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_checks++;
        if ({m_if.req_wr, m_if.req_rd} !== 2'b00) begin
            n_fail++; $display("FAIL reset_m_req: got %b want 00", {m_if.req_wr, m_if.req_rd});
        end
        n_checks++;
        if ({m_if.req_addr, m_if.req_data} !== 52'h0) begin
            n_fail++; $display("FAIL reset_m_addr_data: got %h want 0", {m_if.req_addr, m_if.req_data});
        end
        n_checks++;
        if ({s0_if.resp_ack, s0_if.resp_status, s0_if.resp_data} !== 35'h0) begin
            n_fail++; $display("FAIL reset_s0_resp: got %h want 0", s0_if.resp_data);
        end
        n_checks++;
        if ({s1_if.resp_ack, s1_if.resp_status, s1_if.resp_data} !== 35'h0) begin
            n_fail++; $display("FAIL reset_s1_resp: got %h want 0", s1_if.resp_data);
        end
        n_checks++;
        if (overflow !== 2'b00) begin
            n_fail++; $display("FAIL reset_overflow: got %b want 00", overflow);
        end
    endtask

    task automatic test_write();
        step();
        s0_if.req_wr = 1; s0_if.req_addr = 20'h00123; s0_if.req_data = 32'hDEADBEEF;
        step();
        s0_if.req_wr = 0;
        n_checks++;
        if (m_if.req_wr !== 1'b0) begin
            n_fail++; $display("FAIL wr_early: got %b want 0", m_if.req_wr);
        end
        step();
        n_checks++;
        if ({m_if.req_wr, m_if.req_rd} !== 2'b10) begin
            n_fail++; $display("FAIL wr_pulse: got %b want 10", {m_if.req_wr, m_if.req_rd});
        end
        n_checks++;
        if ({m_if.req_addr, m_if.req_data} !== {20'h00123, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL wr_addr_data: got %h/%h want 00123/deadbeef",
                               m_if.req_addr, m_if.req_data);
        end
        step();
        n_checks++;
        if ({m_if.req_wr, m_if.req_addr} !== {1'b0, 20'h00123}) begin
            n_fail++; $display("FAIL wr_single_pulse_hold: got %b/%h want 0/00123",
                               m_if.req_wr, m_if.req_addr);
        end
        m_if.resp_ack = 1; m_if.resp_status = 2'b00;
        step();
        m_if.resp_ack = 0;
        n_checks++;
        if ({s0_if.resp_ack, s0_if.resp_status} !== 3'b100) begin
            n_fail++; $display("FAIL wr_s0_ack: got %b/%b want 1/00", s0_if.resp_ack, s0_if.resp_status);
        end
        n_checks++;
        if (s1_if.resp_ack !== 1'b0) begin
            n_fail++; $display("FAIL wr_s1_quiet: got %b want 0", s1_if.resp_ack);
        end
        step();
        n_checks++;
        if (s0_if.resp_ack !== 1'b0) begin
            n_fail++; $display("FAIL wr_ack_one_cycle: got %b want 0", s0_if.resp_ack);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        step();
        s0_if.req_rd = 1; s0_if.req_addr = 20'h0AAAA;
        s1_if.req_rd = 1; s1_if.req_addr = 20'h0BBBB;
        step();
        clear_inputs();
        step();
        n_checks++;
        if ({m_if.req_rd, m_if.req_addr} !== {1'b1, 20'h0BBBB}) begin
            n_fail++; $display("FAIL rr_first_s1: got %b/%h want 1/0bbbb", m_if.req_rd, m_if.req_addr);
        end
        step();
        m_if.resp_ack = 1; m_if.resp_data = 32'h11111111;
        step();
        clear_inputs();
        n_checks++;
        if ({s1_if.resp_ack, s1_if.resp_data} !== {1'b1, 32'h11111111}) begin
            n_fail++; $display("FAIL rr_s1_data: got %b/%h want 1/11111111",
                               s1_if.resp_ack, s1_if.resp_data);
        end
        n_checks++;
        if ({s0_if.resp_ack, s0_if.resp_data} !== 33'h0) begin
            n_fail++; $display("FAIL rr_s0_quiet: got %b/%h want 0/0", s0_if.resp_ack, s0_if.resp_data);
        end
        step();
        n_checks++;
        if ({m_if.req_rd, m_if.req_addr} !== {1'b1, 20'h0AAAA}) begin
            n_fail++; $display("FAIL rr_second_s0: got %b/%h want 1/0aaaa", m_if.req_rd, m_if.req_addr);
        end
        step();
        m_if.resp_ack = 1; m_if.resp_data = 32'h22222222;
        step();
        clear_inputs();
        n_checks++;
        if ({s0_if.resp_ack, s0_if.resp_data} !== {1'b1, 32'h22222222}) begin
            n_fail++; $display("FAIL rr_s0_data: got %b/%h want 1/22222222",
                               s0_if.resp_ack, s0_if.resp_data);
        end
        n_checks++;
        if (s1_if.resp_ack !== 1'b0) begin
            n_fail++; $display("FAIL rr_s1_quiet: got %b want 0", s1_if.resp_ack);
        end
    endtask

    task automatic test_overflow();
        int pulses;
        pulses = 0;
        do_reset();
        step();
        s0_if.req_wr = 1; s0_if.req_addr = 20'h00010;
        step();
        s0_if.req_addr = 20'h00020;
        step();
        clear_inputs();
        n_checks++;
        if ({m_if.req_wr, m_if.req_addr} !== {1'b1, 20'h00010}) begin
            n_fail++; $display("FAIL ovf_first_kept: got %b/%h want 1/00010", m_if.req_wr, m_if.req_addr);
        end
        n_checks++;
        if (overflow !== 2'b01) begin
            n_fail++; $display("FAIL ovf_flag: got %b want 01", overflow);
        end
        step();
        m_if.resp_ack = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            m_if.resp_ack = 0;
            if (m_if.req_wr || m_if.req_rd) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL ovf_single_issue: got %0d extra requests want 0", pulses);
        end
        n_checks++;
        if (overflow !== 2'b01) begin
            n_fail++; $display("FAIL ovf_sticky: got %b want 01", overflow);
        end
    endtask

    task automatic test_back_to_back_reload();
        do_reset();
        step();
        s0_if.req_wr = 1; s0_if.req_addr = 20'h00100;
        step();
        clear_inputs();
        step();
        step();
        m_if.resp_ack = 1;
        s0_if.req_wr = 1; s0_if.req_addr = 20'h00200; s0_if.req_data = 32'h2;
        step();
        clear_inputs();
        n_checks++;
        if ({s0_if.resp_ack, overflow} !== 3'b100) begin
            n_fail++; $display("FAIL reload_ack_no_ovf: got %b/%b want 1/00", s0_if.resp_ack, overflow);
        end
        step();
        n_checks++;
        if ({m_if.req_wr, m_if.req_addr, m_if.req_data} !== {1'b1, 20'h00200, 32'h2}) begin
            n_fail++; $display("FAIL reload_issue: got %b/%h/%h want 1/00200/2",
                               m_if.req_wr, m_if.req_addr, m_if.req_data);
        end
        step();
        m_if.resp_ack = 1;
        step();
        clear_inputs();
        n_checks++;
        if (s0_if.resp_ack !== 1'b1) begin
            n_fail++; $display("FAIL reload_second_ack: got %b want 1", s0_if.resp_ack);
        end
    endtask

    task automatic test_stale_ack();
        step();
        m_if.resp_ack = 1; m_if.resp_status = 2'b11; m_if.resp_data = 32'hBAD;
        step();
        clear_inputs();
        n_checks++;
        if ({s0_if.resp_ack, s1_if.resp_ack, s0_if.resp_status, s1_if.resp_status} !== 6'h0) begin
            n_fail++; $display("FAIL stale_ack: got %b%b want 00", s0_if.resp_ack, s1_if.resp_ack);
        end
        n_checks++;
        if ({m_if.req_wr, m_if.req_rd} !== 2'b00) begin
            n_fail++; $display("FAIL stale_no_req: got %b want 00", {m_if.req_wr, m_if.req_rd});
        end
    endtask

    task automatic test_reset_in_wait();
        step();
        s1_if.req_rd = 1; s1_if.req_addr = 20'h00300;
        step();
        clear_inputs();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_if.resp_ack = 1; m_if.resp_data = 32'h999;
        n_checks++;
        if ({s0_if.resp_ack, s1_if.resp_ack, m_if.req_rd, m_if.req_addr} !== 23'h0) begin
            n_fail++; $display("FAIL rstwait_outputs: got %b%b%b/%h want 000/0",
                               s0_if.resp_ack, s1_if.resp_ack, m_if.req_rd, m_if.req_addr);
        end
        step();
        clear_inputs();
        n_checks++;
        if ({s0_if.resp_ack, s1_if.resp_ack} !== 2'b00) begin
            n_fail++; $display("FAIL rstwait_no_ack: got %b%b want 00", s0_if.resp_ack, s1_if.resp_ack);
        end
        step();
        s0_if.req_rd = 1; s0_if.req_addr = 20'h00400;
        step();
        clear_inputs();
        step();
        n_checks++;
        if ({m_if.req_rd, m_if.req_addr} !== {1'b1, 20'h00400}) begin
            n_fail++; $display("FAIL rstwait_next_issue: got %b/%h want 1/00400",
                               m_if.req_rd, m_if.req_addr);
        end
        step();
        m_if.resp_ack = 1; m_if.resp_data = 32'h44;
        step();
        clear_inputs();
        n_checks++;
        if ({s0_if.resp_ack, s0_if.resp_data} !== {1'b1, 32'h44}) begin
            n_fail++; $display("FAIL rstwait_next_ack: got %b/%h want 1/44", s0_if.resp_ack, s0_if.resp_data);
        end
    endtask

`ifdef CTRLPORT_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        step();
        s0_if.req_rd = 1; s0_if.req_addr = 20'h00500;
        step();
        clear_inputs();
        m_if.resp_data = 32'hFFFFFFFF;
        repeat (17) step();
        n_checks++;
        if (s0_if.resp_ack !== 1'b0) begin
            n_fail++; $display("FAIL tmo_not_early: got %b want 0", s0_if.resp_ack);
        end
        step();
        n_checks++;
        if ({s0_if.resp_ack, s0_if.resp_status, s0_if.resp_data} !== {1'b1, 2'b01, 32'h0}) begin
            n_fail++; $display("FAIL tmo_cmderr: got %b/%b/%h want 1/01/0",
                               s0_if.resp_ack, s0_if.resp_status, s0_if.resp_data);
        end
        step();
        m_if.resp_ack = 1;
        step();
        clear_inputs();
        n_checks++;
        if ({s0_if.resp_ack, s1_if.resp_ack} !== 2'b00) begin
            n_fail++; $display("FAIL tmo_late_ack: got %b%b want 00", s0_if.resp_ack, s1_if.resp_ack);
        end
        step();
        s0_if.req_rd = 1; s0_if.req_addr = 20'h00600;
        step();
        clear_inputs();
        repeat (17) step();
        m_if.resp_ack = 1; m_if.resp_status = 2'b00; m_if.resp_data = 32'h5A5A5A5A;
        step();
        clear_inputs();
        n_checks++;
        if ({s0_if.resp_ack, s0_if.resp_status, s0_if.resp_data} !== {1'b1, 2'b00, 32'h5A5A5A5A}) begin
            n_fail++; $display("FAIL tmo_ack_wins: got %b/%b/%h want 1/00/5a5a5a5a",
                               s0_if.resp_ack, s0_if.resp_status, s0_if.resp_data);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_write();
        test_round_robin();
        test_overflow();
        test_back_to_back_reload();
        test_stale_ack();
        test_reset_in_wait();
`ifdef CTRLPORT_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
